// File: rtl/obs_spawner.sv
// obs_spawner: spawns one obstacle at a time at the right screen edge,
// scrolls it left once per frame, and ramps the scroll speed as obstacles clear.
module obs_spawner #(
  parameter int unsigned CONV       = 0,
  parameter int unsigned SPAWN_X    = 640,
  parameter int unsigned SPEED_INIT = 4,
  parameter int unsigned SPEED_MAX  = 12,
  parameter int unsigned SPEED_STEP = 8,
  parameter int unsigned GAP_MIN    = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_frame_tick,
  input  logic            i_run,
  input  logic            i_freeze,
  output logic [2:0]      o_obs_type,
  output logic [9-CONV:0] o_xpos,
  output logic            o_obs_active,
  output logic            o_cleared,
  output logic [3:0]      o_speed
);

  localparam int unsigned XW = 10 - CONV;

  localparam logic [XW-1:0] SPAWN_X_V    = XW'(SPAWN_X);
  localparam logic [3:0]    SPEED_INIT_V = 4'(SPEED_INIT);
  localparam logic [3:0]    SPEED_MAX_V  = 4'(SPEED_MAX);
  localparam logic [7:0]    SPEED_STEP_V = 8'(SPEED_STEP);
  localparam logic [7:0]    GAP_MIN_V    = 8'(GAP_MIN);
  localparam logic [15:0]   LFSR_SEED    = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MOVE = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [15:0]     lfsr_q,     lfsr_d;
  logic [7:0]      gap_q,      gap_d;
  logic [7:0]      clr_cnt_q,  clr_cnt_d;
  logic [3:0]      speed_q,    speed_d;
  logic [2:0]      obs_type_q, obs_type_d;
  logic [XW-1:0]   xpos_q,     xpos_d;
  logic            active_q,   active_d;
  logic            cleared_q,  cleared_d;

  logic            tick;
  logic            lfsr_fb;
  logic [7:0]      clr_cnt_inc;
  logic [XW-1:0]   speed_ext;

  assign tick        = i_frame_tick;
  assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign clr_cnt_inc = clr_cnt_q + 8'd1;
  assign speed_ext   = XW'(speed_q);

  // Next-state: run drop beats freeze, freeze beats tick; decisions use the pre-advance LFSR.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    gap_d      = gap_q;
    clr_cnt_d  = clr_cnt_q;
    speed_d    = speed_q;
    obs_type_d = obs_type_q;
    xpos_d     = xpos_q;
    active_d   = active_q;
    cleared_d  = 1'b0;

    if (!i_run) begin
      state_d    = IDLE;
      obs_type_d = 3'd0;
      active_d   = 1'b0;
      xpos_d     = SPAWN_X_V;
      speed_d    = SPEED_INIT_V;
      clr_cnt_d  = '0;
    end else if (!i_freeze) begin
      if (tick) begin
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
      end

      unique case (state_q)
        IDLE: begin
          state_d = WAIT;
          gap_d   = GAP_MIN_V;
        end

        WAIT: begin
          if (tick) begin
            if (gap_q <= 8'd1) begin
              state_d    = MOVE;
              xpos_d     = SPAWN_X_V;
              obs_type_d = (lfsr_q[2:0] == 3'd0) ? 3'd1 : lfsr_q[2:0];
              active_d   = 1'b1;
            end else begin
              gap_d = gap_q - 8'd1;
            end
          end
        end

        MOVE: begin
          if (tick) begin
            if (xpos_q < speed_ext) begin
              state_d    = WAIT;
              obs_type_d = 3'd0;
              active_d   = 1'b0;
              xpos_d     = SPAWN_X_V;
              cleared_d  = 1'b1;
              gap_d      = GAP_MIN_V + {4'd0, lfsr_q[3:0]};
              if (clr_cnt_inc == SPEED_STEP_V) begin
                clr_cnt_d = '0;
                speed_d   = (speed_q >= SPEED_MAX_V) ? SPEED_MAX_V : speed_q + 4'd1;
              end else begin
                clr_cnt_d = clr_cnt_inc;
              end
            end else begin
              xpos_d = xpos_q - speed_ext;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      gap_q      <= '0;
      clr_cnt_q  <= '0;
      speed_q    <= SPEED_INIT_V;
      obs_type_q <= 3'd0;
      xpos_q     <= SPAWN_X_V;
      active_q   <= 1'b0;
      cleared_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      gap_q      <= gap_d;
      clr_cnt_q  <= clr_cnt_d;
      speed_q    <= speed_d;
      obs_type_q <= obs_type_d;
      xpos_q     <= xpos_d;
      active_q   <= active_d;
      cleared_q  <= cleared_d;
    end
  end

  assign o_obs_type   = obs_type_q;
  assign o_xpos       = xpos_q;
  assign o_obs_active = active_q;
  assign o_cleared    = cleared_q;
  assign o_speed      = speed_q;

endmodule

// File: tb/tb_obs_spawner.sv
// Directed bench for obs_spawner: vector table plus hand-written spawn/scroll/ramp sequences.
module tb_obs_spawner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_frame_tick = 1'b0;
  logic       i_run = 1'b0;
  logic       i_freeze = 1'b0;
  logic [2:0] o_obs_type;
  logic [9:0] o_xpos;
  logic       o_obs_active;
  logic       o_cleared;
  logic [3:0] o_speed;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] lfsr_m   = 16'hACE1;
  int unsigned nclr     = 0;
  int unsigned spd_m    = 4;

  obs_spawner #(
    .CONV      (0),
    .SPAWN_X   (640),
    .SPEED_INIT(4),
    .SPEED_MAX (12),
    .SPEED_STEP(8),
    .GAP_MIN   (30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_frame_tick(i_frame_tick),
    .i_run       (i_run),
    .i_freeze    (i_freeze),
    .o_obs_type  (o_obs_type),
    .o_xpos      (o_xpos),
    .o_obs_active(o_obs_active),
    .o_cleared   (o_cleared),
    .o_speed     (o_speed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       run;
    logic       frz;
    logic       tk;
    logic [2:0] e_type;
    logic [9:0] e_x;
    logic       e_act;
    logic       e_clr;
    logic [3:0] e_spd;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one clock cycle, sample 1 time unit after the edge, then advance the LFSR shadow.
  task automatic step(input logic r, input logic rn, input logic fz, input logic tk);
    rst          = r;
    i_run        = rn;
    i_freeze     = fz;
    i_frame_tick = tk;
    @(posedge clk);
    #1;
    if (r) lfsr_m = 16'hACE1;
    else if (rn && !fz && tk) lfsr_m = lfsr_next(lfsr_m);
    i_frame_tick = 1'b0;
  endtask

  task automatic wait_spawn(input int unsigned exp_gap, input string nm);
    int unsigned n = 0;
    bit seen = 0;
    logic [15:0] pre = lfsr_m;
    logic [2:0] et;
    while (n < 100 && !seen) begin
      pre = lfsr_m;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n++;
      if (o_obs_active) seen = 1;
    end
    et = (pre[2:0] == 3'd0) ? 3'd1 : pre[2:0];
    chk({nm, "_gap"},  n, exp_gap);
    chk({nm, "_type"}, o_obs_type, et);
    chk({nm, "_x"},    o_xpos, 640);
    chk({nm, "_clr"},  o_cleared, 0);
  endtask

  task automatic wait_clear(input int unsigned exp_ticks, input string nm, output int unsigned gap);
    int unsigned n = 0;
    bit seen = 0;
    logic [15:0] pre = lfsr_m;
    while (n < 700 && !seen) begin
      pre = lfsr_m;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n++;
      if (o_cleared) seen = 1;
    end
    nclr++;
    spd_m = (4 + nclr / 8 > 12) ? 12 : 4 + nclr / 8;
    gap   = 30 + pre[3:0];
    chk({nm, "_ticks"}, n, exp_ticks);
    chk({nm, "_spd"},   o_speed, spd_m);
    chk({nm, "_type"},  o_obs_type, 0);
    chk({nm, "_act"},   o_obs_active, 0);
    chk({nm, "_x"},     o_xpos, 640);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk({nm, "_pulse1"}, o_cleared, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned g;
    bit any_clr;

    // rst, run, freeze, tick, type, x, active, cleared, speed
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 10'd640, 1'b0, 1'b0, 4'd4};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'd640, 1'b0, 1'b0, 4'd4};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 10'd640, 1'b0, 1'b0, 4'd4};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 10'd640, 1'b0, 1'b0, 4'd4};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 10'd640, 1'b0, 1'b0, 4'd4};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'd640, 1'b0, 1'b0, 4'd4};

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].r, vecs[i].run, vecs[i].frz, vecs[i].tk);
      chk($sformatf("vec%0d_type", i), o_obs_type,   vecs[i].e_type);
      chk($sformatf("vec%0d_x", i),    o_xpos,       vecs[i].e_x);
      chk($sformatf("vec%0d_act", i),  o_obs_active, vecs[i].e_act);
      chk($sformatf("vec%0d_clr", i),  o_cleared,    vecs[i].e_clr);
      chk($sformatf("vec%0d_spd", i),  o_speed,      vecs[i].e_spd);
    end

    // First spawn after GAP_MIN ticks, then scroll with a freeze and a long tick-free stretch
    wait_spawn(30, "spawn0");
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("scroll_636", o_xpos, 636);
    repeat (59) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("scroll_400", o_xpos, 400);
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("freeze_x", o_xpos, 400);
    chk("freeze_act", o_obs_active, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("unfreeze_396", o_xpos, 396);
    any_clr = 0;
    repeat (100) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (o_cleared) any_clr = 1;
    end
    chk("notick_x", o_xpos, 396);
    chk("notick_clr", any_clr, 0);
    repeat (99) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("scroll_0", o_xpos, 0);
    chk("scroll_0_act", o_obs_active, 1);
    wait_clear(1, "clr0", g);
    wait_spawn(g, "spawn1");

    // Speed ramp: 71 more obstacles, crossing saturation at 64 clears
    for (int k = 1; k < 72; k++) begin
      wait_clear(640 / spd_m + 1, $sformatf("clr%0d", k), g);
      wait_spawn(g, $sformatf("spawn%0d", k + 1));
    end
    chk("spd_saturated", o_speed, 12);

    // Run drop mid-move
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    nclr  = 0;
    spd_m = 4;
    chk("drop_type", o_obs_type, 0);
    chk("drop_x", o_xpos, 640);
    chk("drop_act", o_obs_active, 0);
    chk("drop_clr", o_cleared, 0);
    chk("drop_spd", o_speed, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("drop_clr2", o_cleared, 0);
    wait_spawn(30, "respawn");

    // Reset coinciding with the tick that would clear
    repeat (160) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_x", o_xpos, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_type", o_obs_type, 0);
    chk("rst_x", o_xpos, 640);
    chk("rst_act", o_obs_active, 0);
    chk("rst_clr", o_cleared, 0);
    chk("rst_spd", o_speed, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_clr", o_cleared, 0);
    wait_spawn(30, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
